output_port_allocator: RTL and testbench

- Per-output-port allocator that sits downstream of the five input-port LBDR units in each router.
- Takes the one-hot port requests they produce and grants the output port to one input at a time, round-robin.
- Holds the grant for the whole packet (HEADER through TAIL).
- Gates flit forwarding with a credit counter that tracks free slots in the downstream input buffer.

---
 rtl/output_port_allocator_pkg.sv | 33 +++
 rtl/rr_arbiter5.sv | 30 +++
 rtl/output_port_allocator.sv | 118 +++++++++++
 tb/tb_output_port_allocator.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/output_port_allocator_pkg.sv
// Shared definitions for the per-output-port allocator:
// flit codes, port indices and the allocator FSM state.
package output_port_allocator_pkg;

    localparam int NUM_PORTS = 5;

    localparam logic [2:0] HEADER  = 3'b001;
    localparam logic [2:0] PAYLOAD = 3'b010;
    localparam logic [2:0] TAIL    = 3'b100;

    localparam logic [2:0] N = 3'd0;
    localparam logic [2:0] E = 3'd1;
    localparam logic [2:0] W = 3'd2;
    localparam logic [2:0] S = 3'd3;
    localparam logic [2:0] L = 3'd4;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } alloc_state_e;

    // (p + k) mod NUM_PORTS for p < NUM_PORTS and k <= NUM_PORTS
    function automatic logic [2:0] wrap_add(input logic [2:0] p,
                                            input logic [2:0] k);
        logic [3:0] s;
        s = {1'b0, p} + {1'b0, k};
        if (s >= 4'(NUM_PORTS)) begin
            s = s - 4'(NUM_PORTS);
        end
        return s[2:0];
    endfunction

endpackage

// File: rtl/rr_arbiter5.sv
// Combinational 5-way round-robin arbiter: the first eligible
// input after rr_ptr_i wins, scanning rr_ptr_i+1 .. rr_ptr_i+5.
module rr_arbiter5
    import output_port_allocator_pkg::*;
(
    input  logic [4:0] elig_i,
    input  logic [2:0] rr_ptr_i,
    output logic [4:0] win_o,
    output logic [2:0] idx_o,
    output logic       any_o
);

    logic [2:0] cand;

    always_comb begin
        win_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            cand = wrap_add(rr_ptr_i, 3'(k));
            if (!any_o && elig_i[cand]) begin
                any_o = 1'b1;
                idx_o = cand;
                win_o = 5'b00001 << cand;
            end
        end
    end

endmodule

// File: rtl/output_port_allocator.sv
// Output-port allocator: round-robin packet-level grant with
// credit-gated flit forwarding toward the downstream buffer.
module output_port_allocator
    import output_port_allocator_pkg::*;
#(
    parameter int CREDITS = 4,
    parameter int CW      = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [4:0]    req,
    input  logic [4:0]    valid,
    input  logic [14:0]   flit_id_vec,
    input  logic          credit_in,
    output logic [4:0]    grant,
    output logic [2:0]    sel,
    output logic          fwd,
    output logic [CW-1:0] credits,
    output logic          busy,
    output logic          credit_err
);

    alloc_state_e  state_q, state_d;
    logic [4:0]    grant_q, grant_d;
    logic [2:0]    sel_q, sel_d;
    logic [2:0]    ptr_q, ptr_d;
    logic [CW-1:0] cred_q, cred_d;
    logic          err_q, err_d;

    logic [2:0]    fid [NUM_PORTS];
    logic [4:0]    elig;
    logic [4:0]    arb_win;
    logic [2:0]    arb_idx;
    logic          arb_any;
    logic          fwd_c;

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            fid[i]  = flit_id_vec[3*i +: 3];
            elig[i] = req[i] & valid[i] & (fid[i] == HEADER);
        end
    end

    rr_arbiter5 u_arb (
        .elig_i   (elig),
        .rr_ptr_i (ptr_q),
        .win_o    (arb_win),
        .idx_o    (arb_idx),
        .any_o    (arb_any)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        fwd_c   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    state_d = ST_BUSY;
                    grant_d = arb_win;
                    sel_d   = arb_idx;
                end
            end
            ST_BUSY: begin
                // a HEADER on the owner mid-packet is forwarded like any flit
                fwd_c = valid[sel_q] & (cred_q != '0) & ~rst;
                if (fwd_c && fid[sel_q] == TAIL) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    sel_d   = '0;
                    ptr_d   = sel_q;
                end
            end
        endcase
    end

    always_comb begin
        cred_d = cred_q;
        err_d  = err_q;
        if (fwd_c && !credit_in) begin
            cred_d = cred_q - CW'(1);
        end else if (credit_in && !fwd_c) begin
            if (cred_q == CW'(CREDITS)) begin
                err_d = 1'b1;
            end else begin
                cred_d = cred_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            ptr_q   <= L;
            cred_q  <= CW'(CREDITS);
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cred_q  <= cred_d;
            err_q   <= err_d;
        end
    end

    assign grant      = grant_q;
    assign sel        = sel_q;
    assign fwd        = fwd_c;
    assign credits    = cred_q;
    assign busy       = (state_q == ST_BUSY);
    assign credit_err = err_q;

endmodule

// File: tb/tb_output_port_allocator.sv
// Scoreboard bench for output_port_allocator: directed packets,
// forwarded flits checked in order by an independent monitor.
module tb_output_port_allocator;
    import output_port_allocator_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  req = '0;
    logic [4:0]  valid = '0;
    logic [14:0] flit_id_vec = '0;
    logic        credit_in;
    logic        cin_man = 1'b0;
    logic        echo = 1'b0;
    logic [4:0]  grant;
    logic [2:0]  sel;
    logic        fwd;
    logic [2:0]  credits;
    logic        busy;
    logic        credit_err;

    typedef struct packed {
        logic [2:0] port;
        logic [2:0] fid;
    } exp_t;

    exp_t       sb [$];
    logic [2:0] fq [5][$];
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    assign credit_in = echo ? fwd : cin_man;

    output_port_allocator #(.CREDITS(4), .CW(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .valid       (valid),
        .flit_id_vec (flit_id_vec),
        .credit_in   (credit_in),
        .grant       (grant),
        .sel         (sel),
        .fwd         (fwd),
        .credits     (credits),
        .busy        (busy),
        .credit_err  (credit_err)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    function automatic logic [2:0] code_at(input int j, input int len);
        if (j == 0) return HEADER;
        if (j == len - 1) return TAIL;
        return PAYLOAD;
    endfunction

    task automatic push_pkt(input int p, input int len);
        for (int j = 0; j < len; j++) fq[p].push_back(code_at(j, len));
    endtask

    task automatic expect_pkt(input int p, input int len, input int nexp);
        exp_t e;
        for (int j = 0; j < nexp; j++) begin
            e.port = 3'(p);
            e.fid  = code_at(j, len);
            sb.push_back(e);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < 5; i++) begin
            valid[i] = (fq[i].size() > 0);
            flit_id_vec[3*i +: 3] = valid[i] ? fq[i][0] : 3'b000;
        end
        req = valid;
    endtask

    // Input FIFO model: the flit seen with fwd high is consumed at the edge.
    initial begin
        logic       f;
        logic [2:0] sidx;
        forever begin
            @(negedge clk);
            f    = fwd;
            sidx = sel;
            @(posedge clk);
            #1;
            if (f && fq[sidx].size() > 0) void'(fq[sidx].pop_front());
            refresh();
            #2;
            refresh();
        end
    end

    always @(negedge clk) begin
        if (fwd) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL fwd_unexpected: sel %0d, nothing expected", sel);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("fwd_sel", 32'(sel), 32'(e.port));
                chk("fwd_fid", 32'(flit_id_vec[3*sel +: 3]), 32'(e.fid));
                chk("fwd_grant", 32'(grant), 32'(5'b00001 << e.port));
            end
        end
    end

    task automatic reset_checks();
        chk("rst_grant", 32'(grant), 0);
        chk("rst_sel", 32'(sel), 0);
        chk("rst_fwd", 32'(fwd), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(credit_err), 0);
        chk("rst_credits", 32'(credits), 4);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        reset_checks();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0] gexp [3];
        gexp[0] = 5'b00010;
        gexp[1] = 5'b00100;
        gexp[2] = 5'b10000;

        cyc(2);
        rst = 1'b0;
        reset_checks();

        // single 4-flit packet on input 0 drains all credits
        push_pkt(0, 4);
        expect_pkt(0, 4, 4);
        cyc(1);
        chk("t1_grant", 32'(grant), 32'h01);
        chk("t1_sel", 32'(sel), 0);
        chk("t1_busy", 32'(busy), 1);
        for (int k = 0; k < 4; k++) begin
            chk("t1_fwd", 32'(fwd), 1);
            chk("t1_credits", 32'(credits), 32'(4 - k));
            cyc(1);
        end
        chk("t1_busy_end", 32'(busy), 0);
        chk("t1_credits_end", 32'(credits), 0);
        chk("t1_grant_end", 32'(grant), 0);
        do_reset();

        // 6-flit packet stalls on credits, resumes on two pulses
        push_pkt(2, 6);
        expect_pkt(2, 6, 6);
        cyc(1);
        chk("t2_grant", 32'(grant), 32'h04);
        cyc(4);
        chk("t2_stall_cred", 32'(credits), 0);
        chk("t2_stall_fwd", 32'(fwd), 0);
        chk("t2_stall_busy", 32'(busy), 1);
        cyc(2);
        chk("t2_hold_grant", 32'(grant), 32'h04);
        chk("t2_hold_fwd", 32'(fwd), 0);
        cin_man = 1'b1;
        cyc(1);
        cin_man = 1'b0;
        chk("t2_c1_cred", 32'(credits), 1);
        chk("t2_c1_fwd", 32'(fwd), 1);
        cyc(1);
        chk("t2_c1_after", 32'(credits), 0);
        chk("t2_c1_busy", 32'(busy), 1);
        cin_man = 1'b1;
        cyc(1);
        cin_man = 1'b0;
        chk("t2_c2_fwd", 32'(fwd), 1);
        cyc(1);
        chk("t2_end_busy", 32'(busy), 0);
        chk("t2_end_grant", 32'(grant), 0);
        chk("t2_end_cred", 32'(credits), 0);
        do_reset();

        // three contenders, round-robin 1,2,4,1,2,4
        echo = 1'b1;
        for (int r = 0; r < 2; r++) begin
            push_pkt(1, 2);
            push_pkt(2, 2);
            push_pkt(4, 2);
            expect_pkt(1, 2, 2);
            expect_pkt(2, 2, 2);
            expect_pkt(4, 2, 2);
        end
        cyc(1);
        for (int r = 0; r < 6; r++) begin
            chk("t3_grant", 32'(grant), 32'(gexp[r % 3]));
            cyc(2);
            chk("t3_gap_busy", 32'(busy), 0);
            chk("t3_gap_fwd", 32'(fwd), 0);
            cyc(1);
        end
        chk("t3_credits", 32'(credits), 4);

        // credit returned with every flit: no stall
        push_pkt(3, 5);
        expect_pkt(3, 5, 5);
        cyc(1);
        chk("t4_grant", 32'(grant), 32'h08);
        for (int k = 0; k < 5; k++) begin
            chk("t4_fwd", 32'(fwd), 1);
            chk("t4_credits", 32'(credits), 4);
            cyc(1);
        end
        chk("t4_busy_end", 32'(busy), 0);
        chk("t4_credits_end", 32'(credits), 4);
        echo = 1'b0;

        // credit overflow while idle
        cin_man = 1'b1;
        cyc(1);
        cin_man = 1'b0;
        chk("t5_credits", 32'(credits), 4);
        chk("t5_err", 32'(credit_err), 1);
        cyc(3);
        chk("t5_err_sticky", 32'(credit_err), 1);
        chk("t5_credits_hold", 32'(credits), 4);
        do_reset();

        // reset in the middle of a packet on input 3
        push_pkt(3, 4);
        expect_pkt(3, 4, 2);
        cyc(1);
        chk("t6_grant", 32'(grant), 32'h08);
        cyc(2);
        chk("t6_pre_fwd", 32'(fwd), 1);
        chk("t6_pre_cred", 32'(credits), 2);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("t6_grant0", 32'(grant), 0);
        chk("t6_busy0", 32'(busy), 0);
        chk("t6_cred4", 32'(credits), 4);
        chk("t6_fwd0", 32'(fwd), 0);
        fq[3].delete();
        push_pkt(0, 2);
        expect_pkt(0, 2, 2);
        cyc(1);
        chk("t6_new_grant", 32'(grant), 32'h01);
        chk("t6_new_sel", 32'(sel), 0);
        cyc(2);
        chk("t6_new_done", 32'(busy), 0);
        cyc(2);
        chk("sb_drained", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
